sram_like_arbiter: RTL
======================

# sram_like_arbiter

Parametrised arbiter that merges NUM_CH sram-like master channels (channel 0 = instruction fetch, channel 1 = data access, further channels for uncached/debug masters) onto one pipelined memory port. It sits between the `mips` core and the memory/bus interface, replacing the fixed separate inst/data SRAM ports. It adds the following features:

- req/addr_ok/data_ok handshakes
- round-robin arbitration
- in-flight tracking for a fixed-latency memory
- optional kseg0/kseg1 virtual-to-physical address mapping

## Interface

Parameters:
- NUM_CH, 2, number of master channels (1..8).
- MEM_LAT, 1, cycles from memory-port issue to read-data valid (1..4).
- MAP_KSEG, 1, 1 = addresses 0x8000_0000–0xBFFF_FFFF have their top 3 bits cleared before issue; 0 = pass-through.

Ports (all single-bit unless stated). Reset is synchronous and active-high; one clock.
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- ch_req, in, NUM_CH, per-channel request.
- ch_wr, in, NUM_CH, 1 = write.
- ch_wstrb, in, 4*NUM_CH, byte enables for writes.
- ch_addr, in, 32*NUM_CH, virtual address.
- ch_wdata, in, 32*NUM_CH, write data.
- ch_addr_ok, out, NUM_CH, request accepted this cycle.
- ch_data_ok, out, NUM_CH, response for the oldest accepted request of that channel.
- ch_rdata, out, 32, read data; shared bus, qualified by ch_data_ok.
- mem_ready, in, 1, memory can accept an issue this cycle.
- mem_en, out, 1, issue strobe.
- mem_wen, out, 4, byte write enables; 0 for reads.
- mem_addr, out, 32, physical address.
- mem_wdata, out, 32, write data.
- mem_rdata, in, 32, valid exactly MEM_LAT cycles after the issuing cycle.

## Operation

Arbitration:
- Eligible channels have ch_req=1. Arbitration is round-robin, starting from the channel after last_grant.
- last_grant resets to NUM_CH-1, so channel 0 wins the first contest.
- A grant occurs only when mem_ready=1. It combinationally asserts exactly one ch_addr_ok bit and mem_en in the same cycle.
- On a grant, mem_wen = ch_wr ? ch_wstrb : 0, mem_addr is the mapped address, and mem_wdata is that channel's wdata.
- Ungranted channels keep their request held; masters must not change addr/wr/wdata while req=1 and addr_ok=0.

Tracking pipeline:
- A shift pipeline of MEM_LAT stages, each holding {valid, ch_id}.
- On a grant, stage 0 loads {1, granted id}; otherwise it loads valid=0. Stages advance every cycle unconditionally.

Response:
- When the last stage is valid, ch_data_ok[ch_id]=1 and ch_rdata=mem_rdata.
- Writes also return data_ok; rdata is don't-care for writes.

Address mapping:
- With MAP_KSEG=1, addresses in 0x8000_0000–0xBFFF_FFFF map to addr & 0x1FFF_FFFF. All other addresses pass unchanged.

## Timing

- addr_ok/mem_en: same cycle as req, when granted (0-cycle accept).
- data_ok: exactly MEM_LAT cycles after the accepting cycle; this gives back-to-back throughput of one request per cycle. Responses return in issue order.
- Reset: all outputs are 0 (ch_addr_ok, ch_data_ok, mem_en, mem_wen, mem_addr, mem_wdata, ch_rdata). Pipeline valids and last_grant are cleared as described under Operation.
- Reset mid-operation: in-flight entries are dropped and no data_ok is issued for them. Masters are reset by the same rst.
- Simultaneous grant and response for the same channel is legal: that channel sees both addr_ok and data_ok in one cycle.
- mem_ready=0 blocks all grants; the pipeline still drains.
- NUM_CH=1: no arbitration; a grant occurs whenever req & mem_ready.

## Structure

- Shared package `cpu_bus_pkg`:
  - channel-id constants CH_INST=0, CH_DATA=1
  - KSEG base/mask constants
  - in-flight entry typedef {valid, ch_id[$clog2(NUM_CH)-1:0]}
- One natural sub-module: `rr_arbiter` (NUM_CH-wide request vector in, one-hot grant out, last_grant register updated on enable).
- The tracking pipeline and address mapping stay in the top.

## Test plan

- **Reset:** rst high for 3 cycles while all ch_req=1 → all outputs 0. First grant after release goes to channel 0.
- **Single read:** NUM_CH=2, MEM_LAT=1. Channel 1 read of 0x8000_1000 → mem_addr=0x0000_1000 with mem_en in cycle 0. mem_rdata=0xDEADBEEF in cycle 1 → ch_data_ok=2'b10, ch_rdata=0xDEADBEEF.
- **Contention:** both channels hold req for 4 cycles → grants alternate 0,1,0,1. data_ok follows the same order, each exactly MEM_LAT later.
- **Back-pressure:** mem_ready=0 for 3 cycles with requests pending → no addr_ok and no mem_en. Grant occurs in the first cycle mem_ready=1.
- **Write:** channel 1 write, wstrb=4'b0011, addr 0xA000_0004, wdata 0x1234_5678 → mem_wen=4'b0011, mem_addr=0x0000_0004. data_ok MEM_LAT cycles later.
- **Reset mid-flight:** MEM_LAT=3, rst asserted one cycle after a grant → no data_ok ever issued for that request.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// ------------------------------------------------------------------
// cpu_bus_pkg : shared channel ids, kseg mapping constants, in-flight entry
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_bus_pkg;

  localparam int CH_INST = 0;
  localparam int CH_DATA = 1;

  // Ids are sized for the largest supported channel count (8) so that a
  // single-channel build still has a non-zero-width id field.
  localparam int CH_ID_W = 3;

  localparam logic [31:0] KSEG_SEL_MASK = 32'hC000_0000;
  localparam logic [31:0] KSEG_BASE     = 32'h8000_0000;
  localparam logic [31:0] KSEG_MASK     = 32'h1FFF_FFFF;

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t ch_id;
  } inflight_t;

  // kseg0 and kseg1 share the 0b10 top bits; both drop to the low 512 MB.
  function automatic logic [31:0] kseg_map(input logic [31:0] addr, input logic en);
    if (en && ((addr & KSEG_SEL_MASK) == KSEG_BASE)) begin
      return addr & KSEG_MASK;
    end
    return addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_arbiter_if.sv
// ------------------------------------------------------------------
// sram_like_arbiter_if : master-channel and memory-port bundle
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface sram_like_arbiter_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH-1:0]    ch_wr;
  logic [4*NUM_CH-1:0]  ch_wstrb;
  logic [32*NUM_CH-1:0] ch_addr;
  logic [32*NUM_CH-1:0] ch_wdata;
  logic [NUM_CH-1:0]    ch_addr_ok;
  logic [NUM_CH-1:0]    ch_data_ok;
  logic [31:0]          ch_rdata;
  logic                 mem_ready;
  logic                 mem_en;
  logic [3:0]           mem_wen;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  modport slave (
    input  ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata, mem_ready, mem_rdata,
    output ch_addr_ok, ch_data_ok, ch_rdata, mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output ch_req, ch_wr, ch_wstrb, ch_addr, ch_wdata, mem_ready, mem_rdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata, mem_en, mem_wen, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter : round-robin one-hot grant starting after the last winner
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [NUM_CH-1:0] i_req,
  input  wire logic              i_en,
  output logic      [NUM_CH-1:0] o_grant,
  output ch_id_t                 o_grant_id,
  output logic                   o_valid
);

  ch_id_t r_last_grant;
  logic   w_found;

  // Distance d is how far channel i sits after the last winner; lowest wins.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int d = 0; d < NUM_CH; d++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_en && !w_found && i_req[i] &&
            (((i - int'(r_last_grant) - 1 + 2 * NUM_CH) % NUM_CH) == d)) begin
          o_grant[i] = 1'b1;
          o_grant_id = ch_id_t'(i);
          w_found    = 1'b1;
        end
      end
    end
    o_valid = w_found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ch_id_t'(NUM_CH - 1);
    end else if (o_valid) begin
      r_last_grant <= o_grant_id;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ------------------------------------------------------------------
// sram_like_arbiter : merges NUM_CH sram-like masters onto one fixed-latency port
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int MEM_LAT  = 1,
  parameter int MAP_KSEG = 1
) (
  input wire logic           clk,
  input wire logic           rst,
  sram_like_arbiter_if.slave bus
);

  logic [NUM_CH-1:0] w_grant;
  ch_id_t            w_grant_id;
  logic              w_grant_valid;
  logic              w_arb_en;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_wstrb;
  logic              w_sel_wr;
  inflight_t         w_resp;
  logic [NUM_CH-1:0] w_data_ok;
  logic [31:0]       w_rdata;
  inflight_t         r_pipe [MEM_LAT];

  // Gating with rst keeps every output at zero while reset is held.
  assign w_arb_en = bus.mem_ready & ~rst;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .clk        (clk),
    .rst        (rst),
    .i_req      (bus.ch_req),
    .i_en       (w_arb_en),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_valid    (w_grant_valid)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wstrb = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = bus.ch_addr[32*i +: 32];
        w_sel_wdata = bus.ch_wdata[32*i +: 32];
        w_sel_wstrb = bus.ch_wstrb[4*i +: 4];
        w_sel_wr    = bus.ch_wr[i];
      end
    end
  end

  assign bus.ch_addr_ok = w_grant;
  assign bus.mem_en     = w_grant_valid;
  assign bus.mem_wen    = w_sel_wr ? w_sel_wstrb : 4'b0000;
  assign bus.mem_addr   = kseg_map(w_sel_addr, MAP_KSEG != 0);
  assign bus.mem_wdata  = w_sel_wdata;

  // One stage per cycle of memory latency; the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {w_grant_valid, w_grant_id};
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_resp = r_pipe[MEM_LAT-1];

  always_comb begin
    w_data_ok = '0;
    w_rdata   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_resp.valid && (w_resp.ch_id == ch_id_t'(i))) begin
        w_data_ok[i] = 1'b1;
      end
    end
    if (w_resp.valid) begin
      w_rdata = bus.mem_rdata;
    end
  end

  assign bus.ch_data_ok = w_data_ok;
  assign bus.ch_rdata   = w_rdata;

endmodule

`default_nettype wire
